tour_cmd_seq: RTL and testbench

//  Parametrised successor to the tour command mux: sits between the UART wrapper and cmd_proc.

---
 rtl/tour_cmd_seq.sv | 210 +++++++++++++++++++++
 tb/tb_tour_cmd_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd_seq.sv
`timescale 1ns/1ps
// tour_cmd_seq: sits between the UART wrapper and cmd_proc.
// In IDLE it forwards UART commands untouched. During a tour it replays
// NUM_MOVES stored one-hot knight moves, turning each one into a vertical
// command followed by a horizontal command, each handshaked with cmd_proc.
// A UART command carrying ABORT_OP ends a running tour early.
module tour_cmd_seq #(
  parameter int         NUM_MOVES  = 24,
  parameter int         IDX_W      = 5,
  parameter bit         FANFARE_EN = 1'b1,
  parameter logic [3:0] MOVE_OP    = 4'h2,
  parameter logic [3:0] FAN_OP     = 4'h3,
  parameter logic [3:0] ABORT_OP   = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_tour,
  input  logic [7:0]       move,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [IDX_W-1:0] mv_indx,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  output logic [7:0]       resp,
  output logic             uart_clr,
  output logic             tour_busy,
  output logic             tour_done
);

  localparam logic [7:0] HEAD_N    = 8'h00;
  localparam logic [7:0] HEAD_W    = 8'h3F;
  localparam logic [7:0] HEAD_S    = 8'h7F;
  localparam logic [7:0] HEAD_E    = 8'hBF;
  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);
  localparam logic [3:0] HORZ_OP = FANFARE_EN ? FAN_OP : MOVE_OP;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_VERT      = 3'd1,
    S_VERT_WAIT = 3'd2,
    S_HORZ      = 3'd3,
    S_HORZ_WAIT = 3'd4
  } state_e;

  typedef struct packed {
    logic [7:0] vhead;
    logic [3:0] vsq;
    logic [7:0] hhead;
    logic [3:0] hsq;
  } move_dec_t;

  // Lowest set bit selects the knight move; an empty move gives two
  // zero-length commands that both head north.
  function automatic move_dec_t decode_move(input logic [7:0] mv);
    move_dec_t d;
    casez (mv)
      8'b???????1: d = '{HEAD_N, 4'd2, HEAD_W, 4'd1};
      8'b??????10: d = '{HEAD_N, 4'd2, HEAD_E, 4'd1};
      8'b?????100: d = '{HEAD_S, 4'd2, HEAD_W, 4'd1};
      8'b????1000: d = '{HEAD_S, 4'd2, HEAD_E, 4'd1};
      8'b???10000: d = '{HEAD_N, 4'd1, HEAD_W, 4'd2};
      8'b??100000: d = '{HEAD_N, 4'd1, HEAD_E, 4'd2};
      8'b?1000000: d = '{HEAD_S, 4'd1, HEAD_W, 4'd2};
      8'b10000000: d = '{HEAD_S, 4'd1, HEAD_E, 4'd2};
      default:     d = '{HEAD_N, 4'd0, HEAD_N, 4'd0};
    endcase
    return d;
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] mv_indx_q, mv_indx_d;
  logic             tour_done_q, tour_done_d;
  logic             uart_clr_q, uart_clr_d;

  move_dec_t        dec_s;
  logic [15:0]      vert_cmd_s;
  logic [15:0]      horz_cmd_s;
  logic             abort_s;
  logic             last_s;

  assign dec_s      = decode_move(move);
  assign vert_cmd_s = {MOVE_OP, dec_s.vhead, dec_s.vsq};
  assign horz_cmd_s = {HORZ_OP, dec_s.hhead, dec_s.hsq};
  assign abort_s    = cmd_rdy_UART && (cmd_UART[15:12] == ABORT_OP);
  assign last_s     = (mv_indx_q == LAST_IDX);

  assign mv_indx    = mv_indx_q;
  assign tour_done  = tour_done_q;
  assign uart_clr   = uart_clr_q;

  // Drive the cmd_proc-facing outputs from the current state.
  always_comb begin
    cmd       = cmd_UART;
    cmd_rdy   = cmd_rdy_UART;
    resp      = RESP_DONE;
    tour_busy = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd       = cmd_UART;
        cmd_rdy   = cmd_rdy_UART;
        resp      = RESP_DONE;
        tour_busy = 1'b0;
      end
      S_VERT: begin
        cmd       = vert_cmd_s;
        cmd_rdy   = 1'b1;
        resp      = RESP_BUSY;
        tour_busy = 1'b1;
      end
      S_VERT_WAIT: begin
        cmd       = vert_cmd_s;
        cmd_rdy   = 1'b0;
        resp      = RESP_BUSY;
        tour_busy = 1'b1;
      end
      S_HORZ: begin
        cmd       = horz_cmd_s;
        cmd_rdy   = 1'b1;
        resp      = RESP_BUSY;
        tour_busy = 1'b1;
      end
      S_HORZ_WAIT: begin
        cmd       = horz_cmd_s;
        cmd_rdy   = 1'b0;
        resp      = last_s ? RESP_DONE : RESP_BUSY;
        tour_busy = 1'b1;
      end
      default: begin
        cmd       = cmd_UART;
        cmd_rdy   = cmd_rdy_UART;
        resp      = RESP_DONE;
        tour_busy = 1'b0;
      end
    endcase
  end

  // Next-state logic: an abort outranks every handshake in a running tour.
  always_comb begin
    state_d     = state_q;
    mv_indx_d   = mv_indx_q;
    tour_done_d = 1'b0;
    uart_clr_d  = 1'b0;
    if ((state_q != S_IDLE) && abort_s) begin
      state_d    = S_IDLE;
      mv_indx_d  = '0;
      uart_clr_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_tour) begin
            state_d   = S_VERT;
            mv_indx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_VERT: begin
          if (clr_cmd_rdy) state_d = S_VERT_WAIT;
          else             state_d = S_VERT;
        end
        S_VERT_WAIT: begin
          if (send_resp) state_d = S_HORZ;
          else           state_d = S_VERT_WAIT;
        end
        S_HORZ: begin
          if (clr_cmd_rdy) state_d = S_HORZ_WAIT;
          else             state_d = S_HORZ;
        end
        S_HORZ_WAIT: begin
          if (send_resp) begin
            if (last_s) begin
              state_d     = S_IDLE;
              mv_indx_d   = '0;
              tour_done_d = 1'b1;
            end else begin
              state_d   = S_VERT;
              mv_indx_d = mv_indx_q + IDX_W'(1'b1);
            end
          end else begin
            state_d = S_HORZ_WAIT;
          end
        end
        default: begin
          state_d   = S_IDLE;
          mv_indx_d = '0;
        end
      endcase
    end
  end

  // State, move index and the two single-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mv_indx_q   <= '0;
      tour_done_q <= 1'b0;
      uart_clr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mv_indx_q   <= mv_indx_d;
      tour_done_q <= tour_done_d;
      uart_clr_q  <= uart_clr_d;
    end
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
`timescale 1ns/1ps
// Bench for tour_cmd_seq: the stimulus process plays tour solver, UART
// wrapper and cmd_proc; a monitor process checks every accepted command and
// every tour_done / uart_clr pulse against queues filled by the stimulus.
module tb_tour_cmd_seq;

  localparam int NM = 12;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_tour;
  logic [7:0]    move;
  logic [15:0]   cmd_UART;
  logic          cmd_rdy_UART;
  logic          clr_cmd_rdy;
  logic          send_resp;
  logic [IW-1:0] mv_indx;
  logic [15:0]   cmd;
  logic          cmd_rdy;
  logic [7:0]    resp;
  logic          uart_clr;
  logic          tour_busy;
  logic          tour_done;

  logic [7:0]    mem [NM];
  logic [15:0]   exp_q [$];
  int            evt_q [$];   // 1 = tour_done pulse, 2 = uart_clr pulse
  int            n_vec = 0;
  int            n_err = 0;
  int            dy_tbl [8] = '{2, 2, -2, -2, 1, 1, -1, -1};
  int            dx_tbl [8] = '{-1, 1, -1, 1, -2, 2, -2, 2};

  tour_cmd_seq #(.NUM_MOVES(NM), .IDX_W(IW), .FANFARE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start_tour(start_tour), .move(move),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .mv_indx(mv_indx), .cmd(cmd), .cmd_rdy(cmd_rdy), .resp(resp),
    .uart_clr(uart_clr), .tour_busy(tour_busy), .tour_done(tour_done)
  );

  always #5 clk = ~clk;

  assign move = (mv_indx < 4'd12) ? mem[mv_indx] : 8'h00;

  // Reference: {vertical cmd, horizontal cmd} for one stored move.
  function automatic logic [31:0] ref_pair(input logic [7:0] mv);
    int b, dy, dx, ady, adx;
    logic [7:0] vh, hh;
    b = -1;
    for (int k = 7; k >= 0; k--) if (mv[k]) b = k;
    if (b < 0) return {4'h2, 8'h00, 4'h0, 4'h3, 8'h00, 4'h0};
    dy  = dy_tbl[b];
    dx  = dx_tbl[b];
    vh  = (dy > 0) ? 8'h00 : 8'h7F;
    hh  = (dx < 0) ? 8'h3F : 8'hBF;
    ady = (dy < 0) ? -dy : dy;
    adx = (dx < 0) ? -dx : dx;
    return {4'h2, vh, 4'(ady), 4'h3, hh, 4'(adx)};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the first ncmd commands of the tour held in mem.
  task automatic push_tour(input int ncmd);
    logic [31:0] p;
    int c;
    c = 0;
    for (int i = 0; i < NM; i++) begin
      p = ref_pair(mem[i]);
      if (c < ncmd) exp_q.push_back(p[31:16]);
      c++;
      if (c < ncmd) exp_q.push_back(p[15:0]);
      c++;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NM; i++) begin
      case ($urandom_range(0, 3))
        0:       mem[i] = 8'h00;
        1:       mem[i] = 8'(32'd1 << $urandom_range(0, 7));
        default: mem[i] = 8'($urandom);
      endcase
    end
  endtask

  // cmd_proc model: wait for cmd_rdy, accept, check the wait-state outputs,
  // then finish. mode 1 pokes start_tour while waiting, mode 2 skips send_resp.
  task automatic serve(input logic [7:0] e_resp, input logic e_busy, input int e_idx,
                       input bit is_uart, input int mode);
    int waited;
    waited = 0;
    while (cmd_rdy !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (cmd_rdy !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL serve_timeout: got cmd_rdy %b expected 1 within 50 cycles", cmd_rdy);
      return;
    end
    repeat ($urandom_range(0, 2)) tick();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    if (is_uart) cmd_rdy_UART = 1'b0;
    #1;
    check("wait_resp", 32'(resp), 32'(e_resp));
    check("wait_busy", 32'(tour_busy), 32'(e_busy));
    check("wait_idx", 32'(mv_indx), 32'(e_idx));
    if (mode == 1) begin
      start_tour = 1'b1;
      tick();
      start_tour = 1'b0;
      check("start_ignored_rdy", 32'(cmd_rdy), 32'h0);
      check("start_ignored_idx", 32'(mv_indx), 32'(e_idx));
    end
    if (mode != 2) begin
      repeat ($urandom_range(0, 2)) tick();
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
    end
  endtask

  task automatic start_run();
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
  endtask

  // Complete tour, optionally with a UART command left pending throughout.
  task automatic run_full_tour(input bit pend_uart, input int poke_at);
    push_tour(2 * NM);
    evt_q.push_back(1);
    start_run();
    for (int i = 0; i < NM; i++) begin
      serve(8'h5A, 1'b1, i, 1'b0, 0);
      if (pend_uart && i == 0) begin
        cmd_UART     = 16'h2034;
        cmd_rdy_UART = 1'b1;
        exp_q.push_back(16'h2034);
      end
      serve((i == NM - 1) ? 8'hA5 : 8'h5A, 1'b1, i, 1'b0, (i == poke_at) ? 1 : 0);
    end
    check("end_done", 32'(tour_done), 32'h1);
    check("end_busy", 32'(tour_busy), 32'h0);
    check("end_idx", 32'(mv_indx), 32'h0);
    check("end_resp", 32'(resp), 32'hA5);
    tick();
    check("done_pulse_width", 32'(tour_done), 32'h0);
    if (pend_uart) begin
      check("pending_cmd", 32'(cmd), 32'h2034);
      check("pending_rdy", 32'(cmd_rdy), 32'h1);
      serve(8'hA5, 1'b0, 0, 1'b1, 0);
    end
  endtask

  // Monitor: compares each accepted command and each pulse with the queues.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if (cmd_rdy === 1'b1 && clr_cmd_rdy === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL cmd_accept: got %h expected no command", cmd);
          end else begin
            e = exp_q.pop_front();
            check("cmd_accept", 32'(cmd), 32'(e));
          end
        end
        if (tour_done === 1'b1) begin
          n_vec++;
          if (evt_q.size() > 0 && evt_q[0] == 1) void'(evt_q.pop_front());
          else begin
            n_err++;
            $display("FAIL tour_done_pulse: got 1 expected 0");
          end
        end
        if (uart_clr === 1'b1) begin
          n_vec++;
          if (evt_q.size() > 0 && evt_q[0] == 2) void'(evt_q.pop_front());
          else begin
            n_err++;
            $display("FAIL uart_clr_pulse: got 1 expected 0");
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    rst = 1'b1; start_tour = 1'b0; cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    for (int i = 0; i < NM; i++) mem[i] = 8'h00;
    tick();
    tick();
    check("rst_busy", 32'(tour_busy), 32'h0);
    check("rst_idx", 32'(mv_indx), 32'h0);
    check("rst_done", 32'(tour_done), 32'h0);
    check("rst_uclr", 32'(uart_clr), 32'h0);
    check("rst_resp", 32'(resp), 32'hA5);
    check("rst_rdy", 32'(cmd_rdy), 32'h0);
    rst = 1'b0;
    tick();

    // UART pass-through in IDLE.
    cmd_UART = 16'h2034;
    cmd_rdy_UART = 1'b1;
    #1;
    check("idle_cmd", 32'(cmd), 32'h2034);
    check("idle_rdy", 32'(cmd_rdy), 32'h1);
    check("idle_resp", 32'(resp), 32'hA5);
    check("idle_busy", 32'(tour_busy), 32'h0);
    exp_q.push_back(16'h2034);
    serve(8'hA5, 1'b0, 0, 1'b1, 0);

    // Known tour: move 0 = 8'h02, rest 8'h40; start_tour poked mid-tour.
    for (int i = 0; i < NM; i++) mem[i] = 8'h40;
    mem[0] = 8'h02;
    run_full_tour(1'b0, 5);

    // Randomised tours, one with a UART command pending throughout.
    for (int t = 0; t < 3; t++) begin
      fill_random();
      run_full_tour(t == 1, -1);
    end

    // Abort in VERT_WAIT of move 5 with send_resp in the same cycle.
    fill_random();
    push_tour(11);
    start_run();
    for (int i = 0; i < 5; i++) begin
      serve(8'h5A, 1'b1, i, 1'b0, 0);
      serve(8'h5A, 1'b1, i, 1'b0, 0);
    end
    serve(8'h5A, 1'b1, 5, 1'b0, 2);
    cmd_UART = 16'hF000;
    cmd_rdy_UART = 1'b1;
    send_resp = 1'b1;
    evt_q.push_back(2);
    tick();
    send_resp = 1'b0;
    check("abort_uclr", 32'(uart_clr), 32'h1);
    check("abort_busy", 32'(tour_busy), 32'h0);
    check("abort_idx", 32'(mv_indx), 32'h0);
    check("abort_resp", 32'(resp), 32'hA5);
    check("abort_done", 32'(tour_done), 32'h0);
    cmd_rdy_UART = 1'b0;
    tick();
    check("abort_uclr_width", 32'(uart_clr), 32'h0);
    check("abort_no_done", 32'(tour_done), 32'h0);

    // Reset while in HORZ at mv_indx 10.
    fill_random();
    push_tour(21);
    start_run();
    for (int i = 0; i < 10; i++) begin
      serve(8'h5A, 1'b1, i, 1'b0, 0);
      serve(8'h5A, 1'b1, i, 1'b0, 0);
    end
    serve(8'h5A, 1'b1, 10, 1'b0, 0);
    check("horz_rdy", 32'(cmd_rdy), 32'h1);
    check("horz_idx", 32'(mv_indx), 32'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(tour_busy), 32'h0);
    check("midrst_idx", 32'(mv_indx), 32'h0);
    check("midrst_resp", 32'(resp), 32'hA5);
    check("midrst_rdy", 32'(cmd_rdy), 32'h0);
    tick();
    check("midrst_done", 32'(tour_done), 32'h0);

    repeat (3) tick();
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    check("evt_q_drained", 32'(evt_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
